// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage branch resolver. It owns the architectural S/Z/C/V flag
// register, which the ALU writes through flag_we/alu_szcv. It also evaluates
// conditional branches against those flags. A taken branch produces a
// one-cycle redirect pulse to fetch carrying the target PC. It then holds
// `flush` for FLUSH_CYCLES cycles. During that window no new branch is
// accepted.
//
// Parameters
//   FLUSH_CYCLES   cycles `flush` stays high per taken branch (1..7)
//
// Compile-time option
//   BRANCH_STATS_EN  when defined, br_total/br_taken are saturating
//                    statistics counters; otherwise both ports read 0.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   flag_we         write alu_szcv into the flag register this cycle
//   alu_szcv[3:0]   ALU flags {S,Z,C,V}
//   br_valid        branch presented
//   br_ready        unit can accept a branch (IDLE only)
//   br_cond[2:0]    condition code (BE/BLT/BLE/BNE/B, others never taken)
//   br_pc[15:0]     PC of the branch
//   br_disp[7:0]    signed displacement
//   flags[3:0]      flag register {S,Z,C,V}
//   redirect_valid  one-cycle pulse, fetch loads redirect_pc
//   redirect_pc     branch target (held between redirects)
//   flush           squash younger instructions
//   br_total        accepted branches (statistics)
//   br_taken        taken branches (statistics)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_we,
    input  logic [3:0]  alu_szcv,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_pc,
    input  logic [7:0]  br_disp,
    output logic [3:0]  flags,
    output logic        redirect_valid,
    output logic [15:0] redirect_pc,
    output logic        flush,
    output logic [15:0] br_total,
    output logic [15:0] br_taken
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // Condition codes
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b111;

    // REDIRECT already accounts for one flush cycle, so FLUSH covers the rest.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  flush_cnt;
    logic [2:0]  flush_cnt_next;

    logic [3:0]  eval_flags;
    logic        cond_true;
    logic        accept;
    logic        taken_accept;
    logic [15:0] target_pc;

    logic        eval_s;
    logic        eval_z;
    logic        eval_v;

    assign accept       = br_valid && br_ready;
    assign taken_accept = accept && cond_true;

    // A flag write landing in the same cycle as the branch is forwarded, so
    // a compare immediately followed by a branch resolves on the new flags.
    assign eval_flags = flag_we ? alu_szcv : flags;
    assign eval_s     = eval_flags[3];
    assign eval_z     = eval_flags[2];
    assign eval_v     = eval_flags[0];

    // Target wraps modulo 2^16; the displacement is relative to the PC of the
    // instruction following the branch.
    assign target_pc = br_pc + 16'd1 + {{8{br_disp[7]}}, br_disp};

    // Condition decode; unassigned codes are treated as never-taken.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            COND_BE:  cond_true = eval_z;
            COND_BLT: cond_true = eval_s ^ eval_v;
            COND_BLE: cond_true = eval_z | (eval_s ^ eval_v);
            COND_BNE: cond_true = ~eval_z;
            COND_B:   cond_true = 1'b1;
            default:  cond_true = 1'b0;
        endcase
    end

    // Next-state logic: IDLE waits for a taken branch, REDIRECT lasts exactly
    // one cycle, FLUSH counts down the remaining flush cycles.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            ST_IDLE: begin
                if (taken_accept) begin
                    state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (HAS_FLUSH) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end else begin
                    state_next     = ST_IDLE;
                    flush_cnt_next = 3'd0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt <= 3'd1) begin
                    state_next     = ST_IDLE;
                    flush_cnt_next = 3'd0;
                end else begin
                    flush_cnt_next = flush_cnt - 3'd1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                flush_cnt_next = 3'd0;
            end
        endcase
    end

    // State register plus the control outputs, which are registered copies
    // decoded from the next state so they change exactly with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            flush_cnt      <= 3'd0;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            br_ready       <= 1'b1;
        end else begin
            state          <= state_next;
            flush_cnt      <= flush_cnt_next;
            redirect_valid <= (state_next == ST_REDIRECT);
            flush          <= (state_next != ST_IDLE);
            br_ready       <= (state_next == ST_IDLE);
        end
    end

    // Architectural flag register, writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'h0;
        end else if (flag_we) begin
            flags <= alu_szcv;
        end
    end

    // Target register only moves on a taken branch so fetch sees a stable
    // value outside the redirect pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= 16'h0000;
        end else if (taken_accept) begin
            redirect_pc <= target_pc;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total <= 16'h0000;
            br_taken <= 16'h0000;
        end else begin
            if (accept && (br_total != 16'hFFFF)) begin
                br_total <= br_total + 16'd1;
            end
            if (taken_accept && (br_taken != 16'hFFFF)) begin
                br_taken <= br_taken + 16'd1;
            end
        end
    end
`else
    assign br_total = 16'h0000;
    assign br_taken = 16'h0000;
`endif

endmodule
